// File: rtl/div24_pkg.sv
// Shared types and constants for the 24-bit divider sequencing front end.
package div24_pkg;

    localparam int unsigned DIV_WIDTH = 24;

    // Quotient reported for a divide by zero.
    localparam logic [DIV_WIDTH-1:0] DBZ_QUOT = '1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_WAIT = 3'd2,
        ST_FIX  = 3'd3,
        ST_RESP = 3'd4
    } div_state_t;

endpackage : div24_pkg

// File: rtl/div24_sign_fix.sv
// Conditional two's-complement negate; serves as abs() on operands and as
// the sign fix-up on results.
module div24_sign_fix
    import div24_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] res_c_o
);

    // Wraps modulo 2^WIDTH, so the most negative value maps onto itself.
    always_comb begin
        res_c_o = val_i;
        if (neg_i) begin
            res_c_o = (~val_i) + WIDTH'(1);
        end
    end

endmodule : div24_sign_fix

// File: rtl/div24_seq_ctrl.sv
// Request/response sequencer around an external combinational unsigned divider:
// takes operand magnitudes, waits out the divider settling window, fixes signs.
module div24_seq_ctrl
    import div24_pkg::*;
#(
    parameter int unsigned WIDTH      = DIV_WIDTH,
    parameter int unsigned DIV_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_signed,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_quot,
    output logic [WIDTH-1:0] rsp_rem,
    output logic             rsp_dbz,
    output logic             busy,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r
);

    localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    div_state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic             dbz_q, dbz_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_raw_q, quot_raw_d;
    logic [WIDTH-1:0] rem_raw_q, rem_raw_d;
    logic [WIDTH-1:0] div_a_q, div_a_d;
    logic [WIDTH-1:0] div_b_q, div_b_d;
    logic [WIDTH-1:0] rsp_quot_q, rsp_quot_d;
    logic [WIDTH-1:0] rsp_rem_q, rsp_rem_d;
    logic             rsp_dbz_q, rsp_dbz_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             req_ready_q, req_ready_d;
    logic             busy_q, busy_d;

    logic             neg_a_c;
    logic             neg_b_c;
    logic [WIDTH-1:0] abs_a_c;
    logic [WIDTH-1:0] abs_b_c;
    logic [WIDTH-1:0] fix_quot_c;
    logic [WIDTH-1:0] fix_rem_c;

    assign neg_a_c = signed_q & a_q[WIDTH-1];
    assign neg_b_c = signed_q & b_q[WIDTH-1];

    div24_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .val_i   (a_q),
        .neg_i   (neg_a_c),
        .res_c_o (abs_a_c)
    );

    div24_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .val_i   (b_q),
        .neg_i   (neg_b_c),
        .res_c_o (abs_b_c)
    );

    div24_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
        .val_i   (quot_raw_q),
        .neg_i   (neg_quot_q),
        .res_c_o (fix_quot_c)
    );

    div24_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .val_i   (rem_raw_q),
        .neg_i   (neg_rem_q),
        .res_c_o (fix_rem_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        signed_d    = signed_q;
        dbz_d       = dbz_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        cnt_d       = cnt_q;
        quot_raw_d  = quot_raw_q;
        rem_raw_d   = rem_raw_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        rsp_quot_d  = rsp_quot_q;
        rsp_rem_d   = rsp_rem_q;
        rsp_dbz_d   = rsp_dbz_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    a_d      = req_a;
                    b_d      = req_b;
                    signed_d = req_signed;
                    dbz_d    = 1'b0;
                    state_d  = ST_PREP;
                end
            end
            ST_PREP: begin
                if (b_q == '0) begin
                    dbz_d   = 1'b1;
                    state_d = ST_FIX;
                end else begin
                    div_a_d    = abs_a_c;
                    div_b_d    = abs_b_c;
                    neg_quot_d = signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_rem_d  = signed_q & a_q[WIDTH-1];
                    cnt_d      = CNT_W'(DIV_CYCLES - 1);
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    quot_raw_d = div_q;
                    rem_raw_d  = div_r;
                    state_d    = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FIX: begin
                if (dbz_q) begin
                    rsp_quot_d = WIDTH'(DBZ_QUOT);
                    rsp_rem_d  = a_q;
                    rsp_dbz_d  = 1'b1;
                end else begin
                    rsp_quot_d = fix_quot_c;
                    rsp_rem_d  = fix_rem_c;
                    rsp_dbz_d  = 1'b0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags are registered copies of the decoded next state.
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            signed_q    <= 1'b0;
            dbz_q       <= 1'b0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            cnt_q       <= '0;
            quot_raw_q  <= '0;
            rem_raw_q   <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            rsp_quot_q  <= '0;
            rsp_rem_q   <= '0;
            rsp_dbz_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            signed_q    <= signed_d;
            dbz_q       <= dbz_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            cnt_q       <= cnt_d;
            quot_raw_q  <= quot_raw_d;
            rem_raw_q   <= rem_raw_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            rsp_quot_q  <= rsp_quot_d;
            rsp_rem_q   <= rsp_rem_d;
            rsp_dbz_q   <= rsp_dbz_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;
    assign rsp_quot  = rsp_quot_q;
    assign rsp_rem   = rsp_rem_q;
    assign rsp_dbz   = rsp_dbz_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;

endmodule : div24_seq_ctrl

// File: tb/tb_div24_seq_ctrl.sv
// Bench for div24_seq_ctrl with a behavioural combinational divider beside it.
module tb_div24_seq_ctrl;

    localparam int unsigned W          = 24;
    localparam int unsigned DIV_CYCLES = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_signed;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_quot;
    logic [W-1:0] rsp_rem;
    logic         rsp_dbz;
    logic         busy;
    logic [W-1:0] div_a;
    logic [W-1:0] div_b;
    logic [W-1:0] div_q;
    logic [W-1:0] div_r;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [W-1:0] exp_div_a = '0;
    logic [W-1:0] exp_div_b = '0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Unsigned combinational divider.
    assign div_q = (div_b == '0) ? '1 : div_a / div_b;
    assign div_r = (div_b == '0) ? div_a : div_a % div_b;

    div24_seq_ctrl #(.WIDTH(W), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_signed (req_signed),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_quot   (rsp_quot),
        .rsp_rem    (rsp_rem),
        .rsp_dbz    (rsp_dbz),
        .busy       (busy),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_q      (div_q),
        .div_r      (div_r)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Truncating signed/unsigned division reference.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dbz);
        int sa;
        int sbv;
        if (b == '0) begin
            q   = '1;
            r   = a;
            dbz = 1'b1;
        end else if (s) begin
            sa  = $signed(a);
            sbv = $signed(b);
            q   = W'(sa / sbv);
            r   = W'(sa % sbv);
            dbz = 1'b0;
        end else begin
            q   = a / b;
            r   = a % b;
            dbz = 1'b0;
        end
    endfunction

    function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic s);
        return (s && v[W-1]) ? (~v + 1'b1) : v;
    endfunction

    // One request; hold rsp_ready low for 'hold' cycles once the result shows.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                          input int hold, input string tag);
        exp_t e;
        int   t0;
        bit   seen;
        e.q   = eq;
        e.r   = er;
        e.dbz = edbz;
        e.lat = edbz ? 3 : 3 + int'(DIV_CYCLES);
        if (!edbz) begin
            exp_div_a = mag(a, s);
            exp_div_b = mag(b, s);
        end
        rsp_ready = (hold == 0);
        @(negedge clk);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_a      = a;
        req_b      = b;
        req_signed = s;
        sb.push_back(e);
        t0 = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: rsp_valid not seen within 40 cycles", tag);
            rsp_ready = 1'b1;
            return;
        end
        chk({tag, " latency"}, 32'(cyc - t0), 32'(e.lat));
        chk({tag, " quot"}, 32'(rsp_quot), 32'(e.q));
        chk({tag, " rem"}, 32'(rsp_rem), 32'(e.r));
        chk({tag, " dbz"}, 32'(rsp_dbz), 32'(e.dbz));
        chk({tag, " div_a"}, 32'(div_a), 32'(exp_div_a));
        chk({tag, " div_b"}, 32'(div_b), 32'(exp_div_b));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_a     = 24'd3;
            req_b     = 24'd1;
            chk({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " hold quot"}, 32'(rsp_quot), 32'(e.q));
            chk({tag, " hold rem"}, 32'(rsp_rem), 32'(e.r));
            chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, " post rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " post req_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " quot"}, 32'(rsp_quot), 32'd0);
        chk({tag, " rem"}, 32'(rsp_rem), 32'd0);
        chk({tag, " dbz"}, 32'(rsp_dbz), 32'd0);
        chk({tag, " div_a"}, 32'(div_a), 32'd0);
        chk({tag, " div_b"}, 32'(div_b), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, mq, mr;
        logic         rs, md;
        int           stray;

        vecs[0]  = '{24'd100,      24'd7,        1'b0, 24'd14,       24'd2,        1'b0};
        vecs[1]  = '{24'hFFFF9C,   24'd7,        1'b1, 24'hFFFFF2,   24'hFFFFFE,   1'b0};
        vecs[2]  = '{24'd100,      24'hFFFFF9,   1'b1, 24'hFFFFF2,   24'd2,        1'b0};
        vecs[3]  = '{24'h800000,   24'hFFFFFF,   1'b1, 24'h800000,   24'd0,        1'b0};
        vecs[4]  = '{24'h800000,   24'hFFFFFF,   1'b0, 24'd0,        24'h800000,   1'b0};
        vecs[5]  = '{24'd5,        24'd0,        1'b0, 24'hFFFFFF,   24'd5,        1'b1};
        vecs[6]  = '{24'hFFFF9C,   24'hFFFFF9,   1'b1, 24'd14,       24'hFFFFFE,   1'b0};
        vecs[7]  = '{24'hFFFFFB,   24'd0,        1'b1, 24'hFFFFFF,   24'hFFFFFB,   1'b1};
        vecs[8]  = '{24'd7,        24'd100,      1'b0, 24'd0,        24'd7,        1'b0};
        vecs[9]  = '{24'hFFFFFF,   24'd1,        1'b0, 24'hFFFFFF,   24'd0,        1'b0};
        vecs[10] = '{24'd5,        24'd0,        1'b1, 24'hFFFFFF,   24'd5,        1'b1};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_signed = 1'b0;
        rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r, vecs[i].dbz,
                   0, $sformatf("vec%0d", i));
        end

        // Backpressure: result held for 4 cycles while a new request is offered.
        run_op(24'd100, 24'd7, 1'b0, 24'd14, 24'd2, 1'b0, 4, "bp");

        // Model-checked random operands, a few with zero divisor.
        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom);
            rb = (i % 5 == 4) ? '0 : W'($urandom_range(1, 4000));
            if (i % 3 == 0) rb = ~rb + 1'b1;
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, mq, mr, md);
            run_op(ra, rb, rs, mq, mr, md, 0, $sformatf("rnd%0d", i));
        end

        // Reset while waiting on the divider.
        @(negedge clk);
        req_valid  = 1'b1;
        req_a      = 24'd50;
        req_b      = 24'd3;
        req_signed = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        rst = 1'b0;
        exp_div_a = '0;
        exp_div_b = '0;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        chk("midrst no rsp", 32'(stray), 32'd0);
        run_op(24'd9, 24'd4, 1'b0, 24'd2, 24'd1, 1'b0, 0, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_div24_seq_ctrl

// File: doc/div24_seq_ctrl.md
# div24_seq_ctrl

Sequencing and sign-handling front end for the 24-bit combinational unsigned divider. It accepts signed or unsigned divide requests over a valid/ready handshake and registers the operand magnitudes onto the divider inputs. It holds them for a fixed multicycle settling window, then captures quotient and remainder and applies the sign fix-up. The result is returned over a second valid/ready handshake. The divider sits beside this block at the same level of the hierarchy: `div_a`/`div_b` drive it, and `div_q`/`div_r` come back from it.

## Interface
- `WIDTH`, 24: operand and result width.
- `DIV_CYCLES`, 2: cycles the divider inputs are held stable before capture; must be at least 1.

- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_a`  in  WIDTH  dividend.
- `req_b`  in  WIDTH  divisor.
- `req_signed`  in  1  1 = two's-complement operands, 0 = unsigned.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_quot`  out  WIDTH  quotient.
- `rsp_rem`  out  WIDTH  remainder.
- `rsp_dbz`  out  1  divide-by-zero flag.
- `busy`  out  1  state is not IDLE.
- `div_a`, `div_b`  out  WIDTH  registered unsigned operands to the divider.
- `div_q`, `div_r`  in  WIDTH  divider outputs.

## Operation
- FSM states are IDLE, PREP, WAIT, FIX and RESP.
- IDLE
  - `req_ready`=1.
  - On `req_valid`, latch `req_a`, `req_b` and `req_signed`, then go to PREP.
- PREP
  - If b==0, set the dbz flag and go to FIX without touching the divider.
  - Otherwise register `div_a`=|a| and `div_b`=|b|, record `neg_q`=signed&(a[MSB]^b[MSB]) and `neg_r`=signed&a[MSB], load the wait counter with `DIV_CYCLES`-1, and go to WAIT.
  - In unsigned mode the absolute value is the identity.
- WAIT
  - Count down while holding `div_a`/`div_b` stable.
  - At count 0, capture `div_q`/`div_r`, then go to FIX.
- FIX
  - Quotient = `neg_q` ? −q : q; remainder = `neg_r` ? −r : r. Both are WIDTH-bit two's-complement wrap.
  - On dbz: quotient = all ones, remainder = a (unmodified), `rsp_dbz`=1.
  - Register the results, then go to RESP.
- RESP
  - `rsp_valid`=1 and the outputs are held stable.
  - On `rsp_ready`, go to IDLE.
- Arithmetic rules:
  - Truncating division: the remainder takes the sign of the dividend.
  - Signed overflow (0x800000 / 0xFFFFFF) needs no special case. The magnitudes are 0x800000/1, and negation wraps, giving quot=0x800000 and rem=0.
- One request is in flight at a time; `req_ready`=0 in every state except IDLE.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `busy`=0, `rsp_quot`/`rsp_rem`/`div_a`/`div_b`=0, `rsp_dbz`=0, state=IDLE.
- Request handshake in cycle T:
  - Normal path: `rsp_valid` first high in cycle T+3+`DIV_CYCLES` (T+5 at the default).
  - dbz path: `rsp_valid` first high in cycle T+3.
- Response handshake in cycle R: `rsp_valid`=0 and `req_ready`=1 in R+1. The earliest next accept is R+1.
- While `rsp_ready`=0, all `rsp_*` outputs stay constant indefinitely.
- `rst` in any state returns the FSM to IDLE with reset values on the next edge. The in-flight operation is discarded and no response is issued. `rst` overrides a simultaneous handshake.
- `div_a`/`div_b` are updated only in PREP. Outside PREP they keep their last value, except that reset clears them.

## Structure
- Package `div24_pkg` holds:
  - the state enum `div_state_t`;
  - `localparam DIV_WIDTH = 24`;
  - the dbz quotient constant (all ones).
- Sub-module `div24_sign_fix`: combinational conditional negate (abs/negate of a WIDTH-bit value under a control bit). It is instantiated for the operand magnitudes in PREP and for the result fix-up in FIX.
- The divider itself is not instantiated here; the test bench connects it.

## Test plan
- Unsigned 100/7 → quot 14, rem 2, dbz 0, `rsp_valid` at T+5.
- Signed 0xFFFF9C(−100)/7 → quot 0xFFFFF2(−14), rem 0xFFFFFE(−2). Signed 100/0xFFFFF9(−7) → quot 0xFFFFF2, rem 2.
- Overflow and sign-mode check:
  - Signed 0x800000/0xFFFFFF → quot 0x800000, rem 0.
  - Same operands unsigned → quot 0, rem 0x800000.
- Divide by zero: a=5, b=0 → quot 0xFFFFFF, rem 5, dbz 1, `rsp_valid` at T+3. The divider inputs are unchanged.
- Backpressure: hold `rsp_ready`=0 for 4 cycles → outputs stable, `req_ready`=0, and a new `req_valid` is ignored. Result consumed at R → `req_ready`=1 at R+1.
- Reset mid-operation: assert `rst` during WAIT → next cycle all outputs are at reset values, no `rsp_valid` follows, and a new request of 9/4 completes with quot 2, rem 1.
